// File: rtl/event_drv_bfm.sv
//------------------------------------------------------------------------------
// event_drv_bfm : queued SET/CLR/WRITE/PULSE command driver for an event vector
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module event_drv_bfm #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_op,
   input  logic [WIDTH-1:0] i_cmd_mask,
   input  logic [LEN_W-1:0] i_cmd_len,
   output logic [WIDTH-1:0] o_ev,
   output logic             o_busy,
   output logic             o_done
);

   localparam int          c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_AW:0] c_FULL_CNT = (c_AW+1)'(DEPTH);
   localparam logic [1:0]  c_OP_SET    = 2'd0;
   localparam logic [1:0]  c_OP_CLR    = 2'd1;
   localparam logic [1:0]  c_OP_WRITE  = 2'd3;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   logic [1:0]       r_op_mem   [DEPTH];
   logic [WIDTH-1:0] r_mask_mem [DEPTH];
   logic [LEN_W-1:0] r_len_mem  [DEPTH];

   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_ev;
   logic [WIDTH-1:0] w_ev_nxt;
   logic [WIDTH-1:0] r_pmask;
   logic [WIDTH-1:0] w_pmask_nxt;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] w_cnt_nxt;
   logic             r_done;
   logic             w_done_nxt;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_head_op;
   logic [WIDTH-1:0] w_head_mask;
   logic [LEN_W-1:0] w_head_len;

   assign w_full      = (r_count == c_FULL_CNT);
   assign w_empty     = (r_count == '0);
   assign o_cmd_ready = !rst && !w_full;
   assign w_push      = i_cmd_valid && o_cmd_ready;
   assign w_head_op   = r_op_mem[r_rd_ptr];
   assign w_head_mask = r_mask_mem[r_rd_ptr];
   assign w_head_len  = r_len_mem[r_rd_ptr];

   assign o_ev   = r_ev;
   assign o_done = r_done;
   assign o_busy = (r_state != S_IDLE) || !w_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_op_mem[r_wr_ptr]   <= i_cmd_op;
         r_mask_mem[r_wr_ptr] <= i_cmd_mask;
         r_len_mem[r_wr_ptr]  <= i_cmd_len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A pulse loads cnt with len-1 so the HOLD phase plus the clearing edge
   // keeps the bits high for max(len,1) cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_ev_nxt    = r_ev;
      w_pmask_nxt = r_pmask;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               case (w_head_op)
                  c_OP_SET: begin
                     w_ev_nxt   = r_ev | w_head_mask;
                     w_done_nxt = 1'b1;
                  end
                  c_OP_CLR: begin
                     w_ev_nxt   = r_ev & ~w_head_mask;
                     w_done_nxt = 1'b1;
                  end
                  c_OP_WRITE: begin
                     w_ev_nxt   = w_head_mask;
                     w_done_nxt = 1'b1;
                  end
                  default: begin
                     w_ev_nxt    = r_ev | w_head_mask;
                     w_pmask_nxt = w_head_mask;
                     w_cnt_nxt   = (w_head_len == '0) ? '0 : w_head_len - LEN_W'(1);
                     w_state_nxt = S_HOLD;
                  end
               endcase
            end
         end
         S_HOLD: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - LEN_W'(1);
            end else begin
               w_ev_nxt    = r_ev & ~r_pmask;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ev    <= '0;
         r_pmask <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ev    <= w_ev_nxt;
         r_pmask <= w_pmask_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

endmodule

`default_nettype wire

// File: doc/event_drv_bfm.md
EVENT_DRV_BFM -- requirements
Module: event_drv_bfm

Interface
REQ-001 Parameter WIDTH, default 32: width of driven event vector, legal range 1..64.
REQ-002 Parameter DEPTH, default 4: command FIFO entries, power of two, minimum 2.
REQ-003 Parameter LEN_W, default 16: width of pulse-length field.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  block can accept command.
REQ-008 cmd_op  input  2  opcode: 0 SET, 1 CLR, 2 PULSE, 3 WRITE.
REQ-009 cmd_mask  input  WIDTH  bit mask (SET/CLR/PULSE) or value (WRITE).
REQ-010 cmd_len  input  LEN_W  PULSE high time in cycles; ignored otherwise.
REQ-011 ev  output  WIDTH  registered event vector driven into DUT.
REQ-012 busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-013 done  output  1  one-cycle pulse per completed command.

Function
REQ-014 Command accepted on an edge where cmd_valid=1 and cmd_ready=1; {op,mask,len} written to FIFO tail.
REQ-015 cmd_ready = !rst && FIFO not full; no push while full, even if a pop occurs on the same edge.
REQ-016 Simultaneous push and pop on a non-full, non-empty FIFO: both occur; occupancy unchanged.
REQ-017 FSM states: IDLE, HOLD.
REQ-018 IDLE with FIFO non-empty: head popped and executed on that edge; IDLE with FIFO empty: no change.
REQ-019 SET: ev <= ev | mask; stay IDLE; done=1 next cycle.
REQ-020 CLR: ev <= ev & ~mask; stay IDLE; done=1 next cycle.
REQ-021 WRITE: ev <= mask; stay IDLE; done=1 next cycle.
REQ-022 PULSE: ev <= ev | mask; mask latched into pmask; cnt <= max(len,1)-1; go to HOLD.
REQ-023 HOLD, cnt != 0: cnt <= cnt-1; ev held.
REQ-024 HOLD, cnt == 0: ev <= ev & ~pmask; done=1 next cycle; go to IDLE.
REQ-025 PULSE bits therefore high exactly max(len,1) cycles; len=0 behaves as len=1.
REQ-026 Bits set by PULSE that were already 1 before the pulse are cleared at pulse end (no save/restore).
REQ-027 No FIFO pop while in HOLD; commands may still be accepted.
REQ-028 Latency: command accepted at edge E into an empty FIFO with FSM IDLE -> ev updated at edge E+1; done high during cycle after E+1.
REQ-029 Throughput: back-to-back SET/CLR/WRITE execute one per cycle.
REQ-030 done is registered; never high for two cycles per command; consecutive commands give consecutive done cycles.
REQ-031 busy is combinational from registered state: (state != IDLE) || (count != 0).
REQ-032 FIFO pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-033 While rst=1: ev=0, FIFO empty, state=IDLE, cnt=0, pmask=0, done=0, cmd_ready=0, busy=0.
REQ-034 rst asserted mid-PULSE or with queued commands: all discarded; no done emitted; ev=0 on next edge.
REQ-035 First command may be accepted on the first edge with rst=0.

Verification
REQ-036 After reset, SET 0x0000_00F0 then CLR 0x0000_0030 back-to-back -> ev=0xF0 then 0xC0 on consecutive cycles; two consecutive done pulses.
REQ-037 PULSE mask=0x1, len=3 with ev=0 -> ev[0]=1 exactly 3 cycles, then 0; single done on cycle ev returns to 0.
REQ-038 PULSE len=0 mask=0x2 -> ev[1] high exactly 1 cycle; one done.
REQ-039 DEPTH=4: PULSE len=10 followed by 5 WRITEs without waiting -> cmd_ready=0 after 4 queued; WRITEs drain in order after pulse; final ev=last WRITE value; busy=0 afterward.
REQ-040 rst asserted during PULSE len=8 at count 4 -> ev=0, busy=0, done never asserted for that pulse; next SET 0x5 -> ev=0x5.
REQ-041 WIDTH=64 WRITE 0xFFFF_FFFF_FFFF_FFFF then CLR 0x8000_0000_0000_0001 -> ev=0x7FFF_FFFF_FFFF_FFFE.
